// File: rtl/audio_codec_pkg.sv
// Shared constants for the I2S codec master: frame geometry, the bit
// positions inside a 32-bit slot, and the clk phases inside one BCLK.
package audio_codec_pkg;

  localparam int DATA_W      = 24;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_CNT_W = 9;
  localparam int BIT_POS_W   = $clog2(SLOT_BITS);
  localparam int PH_W        = 3;

  // Bit positions within a slot (b = cnt[7:3]); b=0 is the I2S delay bit.
  localparam logic [BIT_POS_W-1:0] BIT_FIRST     = 5'd1;
  localparam logic [BIT_POS_W-1:0] BIT_LAST      = 5'd24;
  localparam logic [BIT_POS_W-1:0] BIT_ADC_LATCH = 5'd25;

  // clk phase within one BCLK period (cnt[2:0]).
  localparam logic [PH_W-1:0] PH_BCLK_FALL = 3'd0;
  localparam logic [PH_W-1:0] PH_BCLK_RISE = 3'd4;
  localparam logic [PH_W-1:0] PH_ADC_WRITE = 3'd5;

  // True for slot positions that carry a sample bit.
  function automatic logic in_data_window(input logic [BIT_POS_W-1:0] b);
    return (b >= BIT_FIRST) && (b <= BIT_LAST);
  endfunction

endpackage

// File: rtl/audio_codec_i2s_shift.sv
// Parallel-load, MSB-first shift register. Serves as the DAC serialiser
// (load a word, read the top bit) and as the ADC deserialiser (shift in).
module audio_codec_i2s_shift #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] par_o
);

  logic [W-1:0] shreg_q;

  // Load has priority; a shift moves every bit one place toward the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= load_val_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[W-2:0], ser_i};
    end
  end

  assign par_o = shreg_q;

endmodule

// File: rtl/audio_codec.sv
// I2S master for an AK4556-class stereo codec. A free-running 9-bit
// counter yields MCLK/BCLK/LRCK directly from register bits; slot and bit
// position decode from the same counter drive the DAC/ADC shifters.
// Strobes are decoded from the next counter value so every registered
// output changes on the same clk edge as the BCLK transition it belongs to.
module audio_codec #(
  parameter int DATA_W    = audio_codec_pkg::DATA_W,
  parameter int PDN_DELAY = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] LCH_DAC,
  input  logic [DATA_W-1:0] RCH_DAC,
  output logic [DATA_W-1:0] LCH_ADC,
  output logic [DATA_W-1:0] RCH_ADC,
  input  logic              SDTI,
  output logic              SDTO,
  output logic              PDN,
  output logic              LRCK,
  output logic              BCLK,
  output logic              MCLK
);
  import audio_codec_pkg::*;

  localparam int PDN_W = $clog2(PDN_DELAY + 1);

  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [PDN_W-1:0]       pdn_cnt_q;
  logic                   pdn_q;
  logic                   sdto_q, sdto_d;
  logic [DATA_W-1:0]      lch_adc_q, rch_adc_q;

  logic                   slot_d;
  logic [BIT_POS_W-1:0]   bit_d;
  logic [PH_W-1:0]        ph_d;

  logic                   dac_load, dac_shift, adc_shift, adc_write;
  logic [DATA_W-1:0]      dac_word, dac_par, adc_par;

  assign cnt_d  = cnt_q + FRAME_CNT_W'(1);
  assign slot_d = cnt_d[FRAME_CNT_W-1];
  assign bit_d  = cnt_d[FRAME_CNT_W-2:PH_W];
  assign ph_d   = cnt_d[PH_W-1:0];

  // The DAC word is sampled while the counter sits at slot position 0, so
  // the very first left slot after reset release is loaded as well.
  assign dac_load  = (cnt_q[FRAME_CNT_W-2:0] == '0);
  assign dac_word  = cnt_q[FRAME_CNT_W-1] ? RCH_DAC : LCH_DAC;
  assign dac_shift = (ph_d == PH_BCLK_FALL) && in_data_window(bit_d);
  assign sdto_d    = in_data_window(bit_d) ? dac_par[DATA_W-1] : 1'b0;

  assign adc_shift = (ph_d == PH_BCLK_RISE) && in_data_window(bit_d);
  assign adc_write = (ph_d == PH_ADC_WRITE) && (bit_d == BIT_ADC_LATCH);

  audio_codec_i2s_shift #(.W(DATA_W)) u_dac_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dac_load),
    .load_val_i (dac_word),
    .shift_i    (dac_shift),
    .ser_i      (1'b0),
    .par_o      (dac_par)
  );

  audio_codec_i2s_shift #(.W(DATA_W)) u_adc_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (1'b0),
    .load_val_i ({DATA_W{1'b0}}),
    .shift_i    (adc_shift),
    .ser_i      (SDTI),
    .par_o      (adc_par)
  );

  // Free-running frame counter; all pin clocks are bits of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Codec power-down release after a fixed number of clk cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdn_cnt_q <= '0;
      pdn_q     <= 1'b0;
    end else if (!pdn_q) begin
      pdn_cnt_q <= pdn_cnt_q + PDN_W'(1);
      if (pdn_cnt_q == PDN_W'(PDN_DELAY - 1)) begin
        pdn_q <= 1'b1;
      end
    end
  end

  // SDTO only moves together with the falling edge of BCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdto_q <= 1'b0;
    end else if (ph_d == PH_BCLK_FALL) begin
      sdto_q <= sdto_d;
    end
  end

  // Publish the deserialised word into the channel of the current slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lch_adc_q <= '0;
      rch_adc_q <= '0;
    end else if (adc_write) begin
      if (slot_d) begin
        rch_adc_q <= adc_par;
      end else begin
        lch_adc_q <= adc_par;
      end
    end
  end

  assign MCLK    = cnt_q[0];
  assign BCLK    = cnt_q[PH_W-1];
  assign LRCK    = cnt_q[FRAME_CNT_W-1];
  assign SDTO    = sdto_q;
  assign PDN     = pdn_q;
  assign LCH_ADC = lch_adc_q;
  assign RCH_ADC = rch_adc_q;

endmodule

// File: tb/tb_audio_codec.sv
// Directed bench for audio_codec. The bench keeps its own count of clk
// edges since reset release (cyc) as the timing reference and samples on
// the falling clk edge.
module tb_audio_codec;

  typedef struct {
    logic [23:0] lch;
    logic [23:0] rch;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } dac_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] lch_dac = '0;
  logic [23:0] rch_dac_v = '0;
  logic [23:0] rch_dac_w;
  logic        loop_en = 1'b0;
  logic        sdti = 1'b0;
  logic [23:0] lch_adc, rch_adc;
  logic        sdto, pdn, lrck, bclk, mclk;

  int total = 0;
  int bad = 0;
  int cyc;

  dac_vec_t vecs[5];

  assign rch_dac_w = loop_en ? rch_adc : rch_dac_v;

  audio_codec dut (
    .clk     (clk),
    .rst     (rst),
    .LCH_DAC (lch_dac),
    .RCH_DAC (rch_dac_w),
    .LCH_ADC (lch_adc),
    .RCH_ADC (rch_adc),
    .SDTI    (sdti),
    .SDTO    (sdto),
    .PDN     (pdn),
    .LRCK    (lrck),
    .BCLK    (bclk),
    .MCLK    (mclk)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Capture one slot on BCLK rises; optionally disturb a DAC input mid-slot.
  task automatic capture_slot(input int start, input int chg_side, input logic [23:0] chg_val,
                              output logic [23:0] word, output logic zero_ok);
    word = '0;
    zero_ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      at_cyc(start + 8 * b + 4);
      if (b >= 1 && b <= 24) word[24 - b] = sdto;
      else if (sdto !== 1'b0) zero_ok = 1'b0;
      if (b == 5) begin
        if (chg_side == 0) lch_dac = chg_val;
        else if (chg_side == 1) rch_dac_v = chg_val;
      end
    end
  endtask

  initial begin
    logic [23:0] w;
    logic        z;
    logic        pm, pb, pl;
    logic [23:0] pat;
    int m_r[2], b_r[2], l_r[2];
    int mc, bc, lc, lrck_low_bclk, pdn_rise, pdn_late, pdn_bad;
    int fs, fd, fg, fh;

    vecs[0] = '{24'hA5A5AF, 24'h5A5A50, 24'hA5A5AF, 24'h5A5A50};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    vecs[2] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};
    vecs[3] = '{24'h800000, 24'h000001, 24'h800000, 24'h000001};
    vecs[4] = '{24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA};

    // reset state and PDN held low through a 25-clk reset
    #2 rst = 1'b1;
    #1;
    chk("rst_clocks", {29'd0, mclk, bclk, lrck}, 32'd0);
    chk("rst_sdto_pdn", {30'd0, sdto, pdn}, 32'd0);
    chk("rst_lch_adc", {8'd0, lch_adc}, 32'd0);
    chk("rst_rch_adc", {8'd0, rch_adc}, 32'd0);
    pdn_bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (pdn !== 1'b0) pdn_bad++;
    end
    chk("pdn_in_reset", pdn_bad, 0);
    rst = 1'b0;

    // clock ratios and PDN release
    m_r = '{0, 0}; b_r = '{0, 0}; l_r = '{0, 0};
    mc = 0; bc = 0; lc = 0; lrck_low_bclk = 0; pdn_rise = -1; pdn_late = 0;
    pm = 1'b0; pb = 1'b0; pl = 1'b0;
    for (int n = 1; n <= 1100; n++) begin
      at_cyc(n);
      if (mclk && !pm) begin if (mc < 2) m_r[mc] = n; mc++; end
      if (bclk && !pb) begin
        if (bc < 2) b_r[bc] = n;
        bc++;
        if (lc == 0 && !lrck) lrck_low_bclk++;
      end
      if (lrck && !pl) begin if (lc < 2) l_r[lc] = n; lc++; end
      if (pdn === 1'b1 && pdn_rise < 0) pdn_rise = n;
      if (pdn_rise >= 0 && pdn !== 1'b1) pdn_late++;
      pm = mclk; pb = bclk; pl = lrck;
    end
    chk("mclk_period", m_r[1] - m_r[0], 2);
    chk("bclk_period", b_r[1] - b_r[0], 8);
    chk("lrck_period", l_r[1] - l_r[0], 512);
    chk("lrck_low_bclks", lrck_low_bclk, 32);
    chk("pdn_rise_cycle", pdn_rise, 1024);
    chk("pdn_stays_high", pdn_late, 0);

    // table-driven DAC serialisation, with mid-slot input disturbance
    for (int k = 0; k < 5; k++) begin
      fs = 1536 + 512 * k;
      at_cyc(fs - 2);
      lch_dac = vecs[k].lch;
      rch_dac_v = vecs[k].rch;
      capture_slot(fs, 0, ~vecs[k].lch, w, z);
      chk($sformatf("dac_left_word_%0d", k), {8'd0, w}, {8'd0, vecs[k].exp_l});
      chk($sformatf("dac_left_pad_%0d", k), {31'd0, z}, 32'd1);
      capture_slot(fs + 256, 1, ~vecs[k].rch, w, z);
      chk($sformatf("dac_right_word_%0d", k), {8'd0, w}, {8'd0, vecs[k].exp_r});
      chk($sformatf("dac_right_pad_%0d", k), {31'd0, z}, 32'd1);
    end
    chk("adc_idle_lch", {8'd0, lch_adc}, 32'd0);
    chk("adc_idle_rch", {8'd0, rch_adc}, 32'd0);

    // SDTI tied high, RCH_ADC looped back to RCH_DAC
    fd = 1536 + 512 * 5;
    at_cyc(fd - 2);
    sdti = 1'b1;
    loop_en = 1'b1;
    at_cyc(fd + 204);
    chk("lch_adc_before_latch", {8'd0, lch_adc}, 32'd0);
    at_cyc(fd + 205);
    chk("lch_adc_ones", {8'd0, lch_adc}, 32'h00FFFFFF);
    at_cyc(fd + 460);
    chk("rch_adc_before_latch", {8'd0, rch_adc}, 32'd0);
    at_cyc(fd + 461);
    chk("rch_adc_ones", {8'd0, rch_adc}, 32'h00FFFFFF);
    capture_slot(fd + 512 + 256, -1, 24'h0, w, z);
    chk("loop_right_word", {8'd0, w}, 32'h00FFFFFF);
    chk("loop_right_pad", {31'd0, z}, 32'd1);

    // right-slot pattern; SDTI high outside b=1..24 must be ignored
    fg = fd + 1024;
    at_cyc(fg - 2);
    loop_en = 1'b0;
    pat = 24'h123456;
    at_cyc(fg + 256);
    sdti = 1'b1;
    for (int b = 1; b <= 24; b++) begin
      at_cyc(fg + 256 + 8 * b);
      sdti = pat[24 - b];
    end
    at_cyc(fg + 456);
    sdti = 1'b1;
    at_cyc(fg + 460);
    chk("rch_adc_hold", {8'd0, rch_adc}, 32'h00FFFFFF);
    at_cyc(fg + 461);
    chk("rch_adc_pattern", {8'd0, rch_adc}, 32'h00123456);
    chk("lch_adc_unchanged", {8'd0, lch_adc}, 32'h00FFFFFF);

    // asynchronous reset in the middle of a right slot
    fh = fg + 512;
    at_cyc(fh + 300);
    chk("pdn_before_mid_rst", {31'd0, pdn}, 32'd1);
    rst = 1'b1;
    lch_dac = 24'h3C3C3C;
    #1;
    chk("midrst_pins", {27'd0, mclk, bclk, lrck, sdto, pdn}, 32'd0);
    chk("midrst_lch_adc", {8'd0, lch_adc}, 32'd0);
    chk("midrst_rch_adc", {8'd0, rch_adc}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("restart_lrck", {31'd0, lrck}, 32'd0);
    chk("restart_pdn", {31'd0, pdn}, 32'd0);
    fork
      capture_slot(0, -1, 24'h0, w, z);
      begin
        at_cyc(204);
        chk("restart_lch_pre", {8'd0, lch_adc}, 32'd0);
        at_cyc(205);
        chk("restart_lch_post", {8'd0, lch_adc}, 32'h00FFFFFF);
        at_cyc(460);
        chk("restart_rch_pre", {8'd0, rch_adc}, 32'd0);
        at_cyc(461);
        chk("restart_rch_post", {8'd0, rch_adc}, 32'h00FFFFFF);
      end
    join
    chk("restart_left_word", {8'd0, w}, 32'h003C3C3C);
    chk("restart_left_pad", {31'd0, z}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
